// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared definitions for the AXI4-Lite memory responder.
// Holds the AXI response codes, the read/write priority encoding and the
// FSM state encoding. It also provides a helper that maps an address-window
// hit to its response code.
package axi_lite_mem_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Priority bit: which side wins when a read and a write are both ready to go.
  localparam logic PRIO_WRITE = 1'b0;
  localparam logic PRIO_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_RESP = 2'd2,
    ST_WR_RESP = 2'd3
  } state_e;

  function automatic logic [1:0] resp_for(input logic hit);
    return hit ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite bus bundle between the core's data-port initiator and the
// memory responder.
// master modport: the initiator, which drives AR/AW/W and the R/B readies.
// slave modport: the responder, which drives the AR/AW/W readies and the R/B
// channels.
interface axi_lite_mem_responder_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, rready, bready,
    input  arready, awready, wready, rdata, rresp, rvalid, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, rready, bready,
    output arready, awready, wready, rdata, rresp, rvalid, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_chan_hold.sv
// One-entry valid/ready capture register for a single AXI request channel.
// Ports:
//   clk, rstn      : clock and asynchronous active-low reset
//   accept_en      : gates ready; it is held low until the first clock after reset
//   valid/ready    : upstream handshake (ready = accept_en && !full)
//   data_in        : payload captured on the handshake
//   clr            : consumer has taken the payload, so the entry empties
//   full, data_out : holding state seen by the consumer
module axi_lite_chan_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             accept_en,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data_out
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready    = accept_en && !full_q;
  assign full     = full_q;
  assign data_out = data_q;

  // Next-state for the entry: clear has priority; a handshake loads the payload.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (valid && ready) begin
      full_d = 1'b1;
      data_d = data_in;
    end else begin
      full_d = full_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder serving one synchronous single-port block RAM.
// AR, AW and W are each captured in their own hold register. An FSM then
// dispatches one access at a time onto the RAM port and returns the R or B
// response. Addresses outside the BASE_ADDR window get SLVERR and do not
// touch the RAM.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset
//   axi       : AXI4-Lite slave side (AR/AW/W in, R/B out)
//   mem_*     : RAM port. mem_en and mem_we pulse for exactly one cycle per
//               dispatch. mem_rdata is valid the cycle after a read enable.
module axi_lite_mem_responder
  import axi_lite_mem_responder_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rstn,
  axi_lite_mem_responder_if.slave   axi,
  output logic                      mem_en,
  output logic [3:0]                mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  localparam int TAG_LSB = MEM_ADDR_WIDTH + 2;

  // Address holds keep only addr[31:2], because byte offsets are ignored.
  logic [29:0] ar_addr_s, aw_addr_s;
  logic [35:0] w_payload_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;
  logic        ar_full_s, aw_full_s, w_full_s;
  logic        ar_clr_s, wr_clr_s;
  logic        ar_hit_s, aw_hit_s;
  logic        rd_pend_s, wr_pend_s;
  logic        unused_addr_bits_s;

  logic        accept_en_q;
  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic                      mem_en_s;
  logic [3:0]                mem_we_s;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_s;
  logic [31:0]               mem_wdata_s;

  // Tag compare of a stored word address against the window base.
  function automatic logic addr_hit(input logic [29:0] word_addr);
    return word_addr[29:MEM_ADDR_WIDTH] == BASE_ADDR[31:TAG_LSB];
  endfunction

  assign unused_addr_bits_s = ^{axi.araddr[1:0], axi.awaddr[1:0]};

  axi_lite_chan_hold #(.WIDTH(30)) u_ar_hold (
    .clk      (clk),
    .rstn     (rstn),
    .accept_en(accept_en_q),
    .valid    (axi.arvalid),
    .data_in  (axi.araddr[31:2]),
    .clr      (ar_clr_s),
    .ready    (axi.arready),
    .full     (ar_full_s),
    .data_out (ar_addr_s)
  );

  axi_lite_chan_hold #(.WIDTH(30)) u_aw_hold (
    .clk      (clk),
    .rstn     (rstn),
    .accept_en(accept_en_q),
    .valid    (axi.awvalid),
    .data_in  (axi.awaddr[31:2]),
    .clr      (wr_clr_s),
    .ready    (axi.awready),
    .full     (aw_full_s),
    .data_out (aw_addr_s)
  );

  axi_lite_chan_hold #(.WIDTH(36)) u_w_hold (
    .clk      (clk),
    .rstn     (rstn),
    .accept_en(accept_en_q),
    .valid    (axi.wvalid),
    .data_in  ({axi.wstrb, axi.wdata}),
    .clr      (wr_clr_s),
    .ready    (axi.wready),
    .full     (w_full_s),
    .data_out (w_payload_s)
  );

  assign w_strb_s  = w_payload_s[35:32];
  assign w_data_s  = w_payload_s[31:0];
  assign ar_hit_s  = addr_hit(ar_addr_s);
  assign aw_hit_s  = addr_hit(aw_addr_s);
  assign rd_pend_s = ar_full_s;
  assign wr_pend_s = aw_full_s && w_full_s;

  // FSM next-state, dispatch decode and response-register updates.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rvalid_d    = rvalid_q;
    bvalid_d    = bvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    ar_clr_s    = 1'b0;
    wr_clr_s    = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 4'b0000;
    mem_addr_s  = ar_addr_s[MEM_ADDR_WIDTH-1:0];
    mem_wdata_s = w_data_s;
    case (state_q)
      ST_IDLE: begin
        if (rd_pend_s && (!wr_pend_s || (prio_q == PRIO_READ))) begin
          ar_clr_s = 1'b1;
          if (ar_hit_s) begin
            mem_en_s = 1'b1;
            state_d  = ST_RD_WAIT;
          end else begin
            // A miss answers immediately with zero data and does not touch the RAM.
            rdata_d  = 32'h0000_0000;
            rresp_d  = RESP_SLVERR;
            rvalid_d = 1'b1;
            state_d  = ST_RD_RESP;
          end
        end else if (wr_pend_s) begin
          wr_clr_s   = 1'b1;
          mem_addr_s = aw_addr_s[MEM_ADDR_WIDTH-1:0];
          bresp_d    = resp_for(aw_hit_s);
          bvalid_d   = 1'b1;
          state_d    = ST_WR_RESP;
          if (aw_hit_s) begin
            mem_en_s = 1'b1;
            mem_we_s = w_strb_s;
          end else begin
            mem_en_s = 1'b0;
            mem_we_s = 4'b0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
        // Alternate the winner only when both sides competed this cycle.
        if (rd_pend_s && wr_pend_s) begin
          prio_d = ~prio_q;
        end else begin
          prio_d = prio_q;
        end
      end
      ST_RD_WAIT: begin
        rdata_d  = mem_rdata;
        rresp_d  = RESP_OKAY;
        rvalid_d = 1'b1;
        state_d  = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (axi.rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RD_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, response channels and the post-reset ready enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accept_en_q <= 1'b0;
      state_q     <= ST_IDLE;
      prio_q      <= PRIO_WRITE;
      rvalid_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      rresp_q     <= RESP_OKAY;
      bresp_q     <= RESP_OKAY;
    end else begin
      accept_en_q <= 1'b1;
      state_q     <= state_d;
      prio_q      <= prio_d;
      rvalid_q    <= rvalid_d;
      bvalid_q    <= bvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      bresp_q     <= bresp_d;
    end
  end

  assign axi.rvalid = rvalid_q;
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
  assign axi.bvalid = bvalid_q;
  assign axi.bresp  = bresp_q;

  // RAM controls are decoded from registered state only, so they cannot glitch on bus inputs.
  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder, with a small behavioural BRAM model.
module tb_axi_lite_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:255];

  int checks   = 0;
  int failures = 0;
  int n_en = 0;
  int n_b  = 0;
  int n_r  = 0;
  int b0, r0, e0;

  axi_lite_mem_responder_if bus ();

  axi_lite_mem_responder #(
    .MEM_ADDR_WIDTH(15),
    .BASE_ADDR     (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .axi      (bus),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with byte enables, read-first.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // Event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_en) n_en <= n_en + 1;
      if (bus.bvalid && bus.bready) n_b <= n_b + 1;
      if (bus.rvalid && bus.rready) n_r <= n_r + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    bus.araddr = 32'h0; bus.arvalid = 1'b0;
    bus.awaddr = 32'h0; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
    bus.rready = 1'b0; bus.bready = 1'b0;
    repeat (2) cyc();
    chk("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h0);
    chk("rst_valids", 32'({bus.rvalid, bus.bvalid}), 32'h0);
    chk("rst_mem", 32'({mem_en, mem_we}), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_resps", 32'({bus.rresp, bus.bresp}), 32'h0);
    rstn = 1'b1;
    cyc();
    chk("post_rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);

    // 1: AW and W together
    bus.bready = 1'b1; bus.rready = 1'b1;
    drive_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    cyc();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'hF);
    chk("t1_mem_addr", 32'(mem_addr), 32'd4);
    chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t1_bvalid_early", 32'(bus.bvalid), 32'd0);
    cyc();
    chk("t1_bvalid", 32'(bus.bvalid), 32'd1);
    chk("t1_bresp", 32'(bus.bresp), 32'd0);
    chk("t1_mem_en_pulse", 32'(mem_en), 32'd0);
    cyc();
    chk("t1_bvalid_drop", 32'(bus.bvalid), 32'd0);

    // 2: W three cycles ahead of AW
    b0 = n_b;
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    cyc();
    bus.wvalid = 1'b0;
    chk("t2_wready", 32'(bus.wready), 32'd0);
    cyc(); cyc();
    chk("t2_wready_held", 32'(bus.wready), 32'd0);
    chk("t2_no_mem", 32'(mem_en), 32'd0);
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    cyc();
    bus.awvalid = 1'b0;
    chk("t2_mem_we", 32'(mem_we), 32'hF);
    chk("t2_mem_addr", 32'(mem_addr), 32'd5);
    cyc();
    chk("t2_bvalid", 32'(bus.bvalid), 32'd1);
    chk("t2_we_drop", 32'(mem_we), 32'h0);
    repeat (3) cyc();
    chk("t2_b_count", 32'(n_b - b0), 32'd1);

    // 3: read hit with rready held low
    bus.rready = 1'b0;
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    cyc();
    bus.arvalid = 1'b0;
    chk("t3_mem_en", 32'({mem_en, mem_we}), 32'h10);
    chk("t3_mem_addr", 32'(mem_addr), 32'd4);
    cyc();
    chk("t3_rvalid_c2", 32'(bus.rvalid), 32'd0);
    cyc();
    chk("t3_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t3_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("t3_rresp", 32'(bus.rresp), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_rvalid_hold", 32'(bus.rvalid), 32'd1);
      chk("t3_rdata_hold", bus.rdata, 32'hDEAD_BEEF);
    end
    bus.rready = 1'b1;
    cyc();
    chk("t3_rvalid_drop", 32'(bus.rvalid), 32'd0);

    // 4: partial strobe, then an all-zero strobe
    drive_wr(32'h20, 32'h0000_AB00, 4'b0010);
    cyc();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t4_mem_we", 32'(mem_we), 32'h2);
    chk("t4_mem_wdata", mem_wdata, 32'h0000_AB00);
    chk("t4_mem_addr", 32'(mem_addr), 32'd8);
    cyc();
    chk("t4_bvalid_bresp", 32'({bus.bvalid, bus.bresp}), 32'h4);
    cyc();
    drive_wr(32'h24, 32'hFFFF_FFFF, 4'b0000);
    cyc();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t4z_mem_en_we", 32'({mem_en, mem_we}), 32'h10);
    cyc();
    chk("t4z_bvalid_bresp", 32'({bus.bvalid, bus.bresp}), 32'h4);
    cyc();

    // 5: out-of-window read and write
    e0 = n_en;
    bus.araddr = 32'h8000_0000; bus.arvalid = 1'b1;
    cyc();
    bus.arvalid = 1'b0;
    chk("t5r_mem_en", 32'(mem_en), 32'd0);
    cyc();
    chk("t5r_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t5r_rresp", 32'(bus.rresp), 32'h2);
    chk("t5r_rdata", bus.rdata, 32'h0);
    cyc();
    drive_wr(32'h0002_0000, 32'h5555_5555, 4'hF);
    cyc();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t5w_mem", 32'({mem_en, mem_we}), 32'h0);
    cyc();
    chk("t5w_bvalid_bresp", 32'({bus.bvalid, bus.bresp}), 32'h6);
    cyc();
    chk("t5_en_count", 32'(n_en - e0), 32'd0);

    // 6: arbitration from reset, then reset during RD_RESP
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    drive_wr(32'h14, 32'hCAFE_F00D, 4'hF);
    cyc();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t6_first_we", 32'(mem_we), 32'hF);
    chk("t6_first_addr", 32'(mem_addr), 32'd5);
    cyc();
    chk("t6_bvalid", 32'(bus.bvalid), 32'd1);
    cyc();
    chk("t6_rd_en_we", 32'({mem_en, mem_we}), 32'h10);
    chk("t6_rd_addr", 32'(mem_addr), 32'd4);
    cyc(); cyc();
    chk("t6_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t6_rdata", bus.rdata, 32'hDEAD_BEEF);
    cyc();
    bus.rready = 1'b0;
    bus.araddr = 32'h14; bus.arvalid = 1'b1;
    drive_wr(32'h10, 32'h0102_0304, 4'hF);
    cyc();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t6b_rd_first", 32'({mem_en, mem_we}), 32'h10);
    chk("t6b_addr", 32'(mem_addr), 32'd5);
    cyc(); cyc();
    chk("t6b_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t6b_rdata", bus.rdata, 32'hCAFE_F00D);
    r0 = n_r; b0 = n_b; e0 = n_en;
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
    cyc();
    rstn = 1'b1;
    bus.rready = 1'b1;
    repeat (6) cyc();
    chk("t6_no_r_after_rst", 32'(n_r - r0), 32'd0);
    chk("t6_no_b_after_rst", 32'(n_b - b0), 32'd0);
    chk("t6_no_mem_after_rst", 32'(n_en - e0), 32'd0);
    chk("t6_valids_after_rst", 32'({bus.rvalid, bus.bvalid}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
AXI4-Lite responder (slave) that terminates the core's data-bus initiator port and serves it from a synchronous single-port block RAM.
- Accepts the core's AR/AW/W channels and returns R/B responses.
- Arbitrates reads and writes onto one RAM port.
- Flags out-of-window addresses with SLVERR.
- Sits between the core's AXI data port and the data BRAM in the top level.

Parameters:
MEM_ADDR_WIDTH, 15, RAM word-address width; window size = 4*2^MEM_ADDR_WIDTH bytes
BASE_ADDR, 32'h0000_0000, byte base of window; must be aligned to window size

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
axi_araddr  in  32  read address
axi_arready  out  1  read address ready
axi_arvalid  in  1  read address valid
axi_bready  in  1  write response ready
axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
axi_bvalid  out  1  write response valid
axi_rdata  out  32  read data
axi_rready  in  1  read data ready
axi_rresp  out  2  read response (00 OKAY, 10 SLVERR)
axi_rvalid  out  1  read data valid
axi_awaddr  in  32  write address
axi_awready  out  1  write address ready
axi_awvalid  in  1  write address valid
axi_wdata  in  32  write data
axi_wready  out  1  write data ready
axi_wstrb  in  4  byte strobes
axi_wvalid  in  1  write data valid
mem_en  out  1  RAM enable (read or write access this cycle)
mem_we  out  4  RAM byte write enables
mem_addr  out  MEM_ADDR_WIDTH  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `rstn`.
- Reset values: all holding regs empty; state IDLE; priority bit = write-first.
  - While `rstn` is low: rvalid, bvalid, mem_en, mem_we and all readies are 0; rdata, rresp, bresp are 0.
  - Readies rise the first cycle after `rstn` deasserts.
- Capture registers (AR, AW, W), each independent:
  - ready = !full.
  - Handshake (valid && ready) loads the payload and sets full.
  - AW and W may arrive in any order or in the same cycle.
  - Low 2 address bits are ignored; word address = addr[MEM_ADDR_WIDTH+1:2].
- Range check: hit iff addr[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2].
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE dispatch (rd_pend = AR full; wr_pend = AW full && W full):
  - If both are pending, the priority bit decides. The bit toggles after every conflict that is resolved.
  - Read dispatch:
    - Clear AR full.
    - Hit: mem_en=1, mem_we=0, go to RD_WAIT.
    - Miss: no RAM access; rdata=0, rresp=10; go to RD_RESP.
  - Write dispatch:
    - Clear AW full and W full.
    - Hit: mem_en=1, mem_we=wstrb, mem_wdata=wdata, bresp=00.
    - Miss: mem_en=0, mem_we=0, bresp=10.
    - Go to WR_RESP.
- RD_WAIT: latch mem_rdata into rdata, rresp=00, go to RD_RESP.
- RD_RESP:
  - rvalid=1; rdata and rresp are held stable.
  - On rready go to IDLE; rvalid drops the next cycle.
- WR_RESP:
  - bvalid=1; bresp is held stable.
  - On bready go to IDLE.
- Latency, with the AR/AW/W handshake edge as cycle 0:
  - Read hit: mem_en in cycle 1, rvalid in cycle 3.
  - Read miss: rvalid in cycle 2.
  - Write: mem_we in cycle 1 after the later of the AW/W handshakes, bvalid in cycle 2.
- Only one transaction is outstanding toward the RAM or response channel. The freed capture register may accept the next request during RD_RESP/WR_RESP.
- mem_en and mem_we are single-cycle pulses, never asserted outside IDLE dispatch.
- Strobe 0000 on a hit still produces a RAM cycle with mem_we=0000 and OKAY; it behaves as a no-op write.
- Reset mid-operation: pending and in-flight transactions are dropped; no response is issued after reset.

Decomposition:
- Shared package holds:
  - Response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - FSM state encoding.
- One sub-module, axi_lite_chan_hold: a parameterised-width valid/ready capture register with a full flag and a clear input, instantiated for AR, AW and W(data+strb).

Test Plan:
1. AW 0x10 and W 0xDEADBEEF/strb F in the same cycle -> next cycle mem_en=1, mem_we=F, mem_addr=4; bvalid one cycle later; bresp=00.
2. W presented 3 cycles before AW 0x14 -> wready=0 after W capture; mem_we pulses the cycle after the AW handshake; one B response only.
3. Read 0x10 with rready held low 5 cycles (RAM model returns 0xDEADBEEF) -> rvalid at cycle 3 and held; rdata stable at 0xDEADBEEF; rresp=00; rvalid drops the cycle after rready.
4. AW 0x20, W 0x0000AB00 strb 0010 -> mem_we=0010, mem_wdata=0x0000AB00, bresp=00.
5. BASE_ADDR=0, MEM_ADDR_WIDTH=15:
   - Read 0x8000_0000 -> mem_en never asserted; rvalid at cycle 2; rresp=10; rdata=0.
   - Write 0x0002_0000 -> mem_we never asserted; bresp=10.
6. AR 0x10 and AW+W 0x14 pending together after reset -> write served first, then read. A second simultaneous pair is served read first. Asserting rstn=0 during RD_RESP -> rvalid=0 immediately; no response after release.
